// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: for a requested ones-count K, streams every WIDTH-bit
// value with exactly K bits set, in ascending order, one per accepted beat.
// Request and pattern sides both use valid/ready handshakes.
module ones_pattern_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_count,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    output logic             pat_last,
    output logic [WIDTH-1:0] pat_index,
    output logic             err
);

    localparam int unsigned XW  = WIDTH + 1;
    localparam int unsigned TZW = $clog2(XW);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t            state;
    logic [CW-1:0]     kk;

    logic [XW-1:0]     x_ext;
    logic [XW-1:0]     low_bit;
    logic [XW-1:0]     ripple;
    logic [TZW-1:0]    tz;
    logic              tz_found;
    logic [WIDTH-1:0]  nxt_data;
    logic [WIDTH-1:0]  first_data;
    logic [WIDTH-1:0]  top_mask;
    logic              req_bad;

    // Next value with the same popcount, plus the first/last patterns for K.
    // Arithmetic runs one bit wider so the carry out of x + lowbit survives.
    always_comb begin
        x_ext    = {1'b0, pat_data};
        low_bit  = x_ext & (~x_ext + XW'(1));
        ripple   = x_ext + low_bit;
        tz       = '0;
        tz_found = 1'b0;
        for (int unsigned i = 0; i < XW; i++) begin
            if (x_ext[i] && !tz_found) begin
                tz       = TZW'(i);
                tz_found = 1'b1;
            end
        end
        nxt_data   = WIDTH'(ripple | (((x_ext ^ ripple) >> 2) >> tz));
        first_data = ~({WIDTH{1'b1}} << req_count);
        top_mask   = {WIDTH{1'b1}} << (CW'(WIDTH) - kk);
        req_bad    = (req_count > CW'(WIDTH));
    end

    // Control FSM with all handshake and data outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kk        <= '0;
            req_ready <= 1'b1;
            pat_valid <= 1'b0;
            pat_data  <= '0;
            pat_last  <= 1'b0;
            pat_index <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            state     <= EMIT;
                            kk        <= req_count;
                            req_ready <= 1'b0;
                            pat_valid <= 1'b1;
                            pat_data  <= first_data;
                            pat_index <= '0;
                            pat_last  <= (req_count == '0) || (req_count == CW'(WIDTH));
                        end
                    end
                end
                EMIT: begin
                    if (pat_valid && pat_ready) begin
                        if (pat_last) begin
                            state     <= IDLE;
                            pat_valid <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            pat_data  <= nxt_data;
                            pat_index <= pat_index + WIDTH'(1);
                            pat_last  <= (nxt_data == top_mask);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    pat_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
- Sequential generator that, for a requested ones-count K, emits every WIDTH-bit pattern with exactly K bits set, in ascending numeric order, one per accepted beat.
- Acts as the stimulus/source side for the team's ones-counting logic: its output stream drives a popcount block, and every emitted beat must count back to K.
- Request in, pattern stream out; both sides use valid/ready handshakes.

Parameters:
- WIDTH, 8, pattern width in bits; legal range is 2 to 16.
- CW, 4, width of the count field; equals ceil(log2(WIDTH+1)), so it can hold the value WIDTH.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_count  input  CW  requested ones-count K.
- pat_valid  output  1  pat_data, pat_last and pat_index are valid.
- pat_ready  input  1  consumer accepts the current beat.
- pat_data  output  WIDTH  current pattern.
- pat_last  output  1  current beat is the final pattern for K.
- pat_index  output  WIDTH  zero-based ordinal of the current beat within the sequence.
- err  output  1  one-cycle pulse when a request with K > WIDTH is accepted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, req_ready=1, pat_valid=0, pat_data=0, pat_last=0, pat_index=0, err=0.
- Reset asserted mid-stream aborts the sequence immediately. No partial beat survives reset.
- State IDLE:
  - req_ready=1, pat_valid=0.
  - A request is accepted on any cycle with req_valid && req_ready.
  - If K > WIDTH: err=1 for the following cycle only; state stays IDLE; no beats are emitted.
  - Otherwise the next cycle is EMIT with:
    - pat_data = (1<<K)-1
    - pat_index = 0
    - pat_valid = 1
    - pat_last = (K==0) || (K==WIDTH)
- State EMIT:
  - req_ready=0; req_valid is ignored.
  - pat_valid stays 1. pat_data, pat_last and pat_index hold stable while pat_ready=0.
  - On a beat handshake (pat_valid && pat_ready):
    - If pat_last=1: go to IDLE next cycle; pat_valid=0; pat_data and pat_index retain their last values.
    - Else: pat_data takes the smallest WIDTH-bit value greater than the current one with the same popcount; pat_index increments by 1.
    - pat_last for the new beat = (new pat_data == K ones packed into the MSBs).
- Latency and throughput:
  - Request accept to first beat: 1 cycle.
  - With pat_ready held at 1: one beat per cycle, no bubbles.
  - From last beat handshake to req_ready=1: 1 cycle. Back-to-back requests therefore leave exactly one idle cycle between streams.
- Sequence length is C(WIDTH,K). The final pat_index is C(WIDTH,K)-1, which fits in WIDTH bits for all legal WIDTH.
- Next-pattern arithmetic:
  - Standard "next bit permutation" step: lowest set bit c = x & -x; r = x + c; next = r | (((x ^ r) >> 2) >> ctz(x)).
  - Computed in WIDTH+1 bits so the carry out of x + c is not lost.
  - Must be single-cycle combinational; no divider allowed.
- Boundaries:
  - K=0: exactly one beat, pat_data=0, pat_last=1.
  - K=WIDTH: exactly one beat, all ones, pat_last=1.
  - K=WIDTH-1 and K=1: WIDTH beats each.
- The invariant popcount(pat_data)==K holds on every cycle where pat_valid=1.

Test Plan:
- K=2, pat_ready=1:
  - Beats 0x03,0x05,0x06,0x09,0x0A,0x0C,0x11,…; 28 beats total.
  - Final beat 0xC0 with pat_last=1 and pat_index=27.
  - req_ready returns to 1 one cycle after the final beat.
- K=0 -> single beat pat_data=0x00, pat_last=1. K=8 -> single beat 0xFF, pat_last=1, pat_index=0.
- K=9 -> err=1 for exactly one cycle, pat_valid stays 0, req_ready stays 1.
- K=4 with pat_ready toggled randomly -> 70 beats, no pattern skipped or duplicated, outputs stable while stalled.
  - Scoreboard checks popcount==4 and strictly ascending values.
- K=3 with rst pulsed after beat 5 -> all outputs return to reset values immediately.
  - A subsequent K=1 request yields 0x01,0x02,…,0x80.
- Back-to-back requests K=1 then K=7 with req_valid held -> second request accepted exactly one cycle after the K=1 last beat.
  - K=7 stream is 0x7F,0xBF,0xDF,0xEF,0xF7,0xFB,0xFD,0xFE.
